// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: FSM states and operation codes.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHU  = 2'b10,
        OP_MULHSU = 2'b11
    } op_t;

    // Operand a is signed for MULH and MULHSU.
    function automatic logic op_a_signed(input logic [1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    // Operand b is signed only for MULH.
    function automatic logic op_b_signed(input logic [1:0] op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add iteration (LSB-first, right-shifting accumulator).
// The multiplicand is added into the upper half when the multiplier bit is set,
// then the whole (2N+1)-bit sum, carry included, shifts right by one.
module mul_step #(
    parameter int N = 64
) (
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   mcand,
    input  logic           mbit,
    output logic [2*N-1:0] acc_nxt
);

    logic [N:0]   sum;
    logic [2*N:0] wide;

    // Add into the upper half, keep the carry, shift right by one
    always_comb begin
        sum     = {1'b0, acc[2*N-1:N]} + (mbit ? {1'b0, mcand} : {(N+1){1'b0}});
        wide    = {sum, acc[N-1:0]};
        acc_nxt = (2*N)'(wide >> 1);
    end

endmodule

// File: rtl/seq_mul.sv
// Sequential N-bit multiplier (MUL/MULH/MULHU/MULHSU) with valid/ready handshakes.
// Operands are converted to magnitudes at acceptance, N shift-add steps run in
// BUSY, and the signed fix-up plus half selection happen on the final step so
// the result register is loaded as the FSM enters DONE.
module seq_mul
    import mul_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_op,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result
);

    localparam int CW = $clog2(N) + 1;

    state_t          state, state_nxt;
    op_t             op;
    logic            sign;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    mcand, mplier;
    logic [2*N-1:0]  acc, acc_nxt, prod;
    logic            a_neg, b_neg, last_step;
    logic [N-1:0]    mag_a, mag_b;

    // Operand sign detection and magnitude conversion; the most negative value
    // maps to itself, which is its correct unsigned magnitude
    always_comb begin
        a_neg     = op_a_signed(i_op) && i_a[N-1];
        b_neg     = op_b_signed(i_op) && i_b[N-1];
        mag_a     = a_neg ? -i_a : i_a;
        mag_b     = b_neg ? -i_b : i_b;
        last_step = (state == BUSY) && (cnt == CW'(N-1));
        prod      = sign ? -acc_nxt : acc_nxt;
    end

    mul_step #(.N(N)) u_step (
        .acc     (acc),
        .mcand   (mcand),
        .mbit    (mplier[0]),
        .acc_nxt (acc_nxt)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid)  state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (i_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
    end

    // Datapath: latch operands on acceptance, iterate in BUSY, load result on the last step
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            op       <= OP_MUL;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        acc    <= '0;
                        cnt    <= '0;
                        sign   <= a_neg ^ b_neg;
                        op     <= op_t'(i_op);
                    end
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step)
                        o_result <= (op == OP_MUL) ? prod[N-1:0] : prod[2*N-1:N];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: the driver pushes expected results, a negedge
// monitor pops and compares on every output handshake and checks timing.
module tb_seq_mul;

    localparam int N = 64;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         i_rst, i_valid, i_ready;
    logic         o_ready, o_valid;
    logic [N-1:0] i_a, i_b, o_result;
    logic [1:0]   i_op;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit b2b   = 1'b0;

    logic [N-1:0] sb[$];

    seq_mul #(.N(N)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_op     (i_op),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: sign/zero-extend to 128 bits and multiply modulo 2^128
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] op);
        logic [127:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b11) ? {{64{a[63]}}, a} : {64'b0, a};
        eb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    // Monitor: result compare, latency, single-cycle valid, back-to-back period
    int  acc_cyc   = 0;
    bit  acc_known = 1'b0;
    bit  prev_v    = 1'b0;
    bit  prev_hs   = 1'b0;
    int  b2b_cnt   = 0;
    always @(negedge clk) begin
        if (i_rst) begin
            prev_v    = 1'b0;
            prev_hs   = 1'b0;
            acc_known = 1'b0;
        end else begin
            if (prev_hs) chk("valid_after_handshake", {63'b0, o_valid}, 64'd0);
            if (o_valid && !prev_v && acc_known)
                chk("latency", 64'(cyc - acc_cyc), 64'd65);
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_result: got %h expected none", o_result);
                end else begin
                    chk("result", o_result, sb.pop_front());
                end
            end
            if (i_valid && o_ready) begin
                if (b2b) begin
                    if (b2b_cnt > 0) chk("b2b_period", 64'(cyc - acc_cyc), 64'd66);
                    b2b_cnt++;
                end
                acc_cyc   = cyc;
                acc_known = 1'b1;
            end
            prev_v  = o_valid;
            prev_hs = o_valid && i_ready;
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                        input logic [63:0] exp, input bit hold);
        int n = 0;
        i_a = a; i_b = b; i_op = op; i_valid = 1'b1;
        sb.push_back(exp);
        while (!o_ready && n < 300) begin @(posedge clk); #1; n++; end
        if (!o_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got o_ready=0 expected 1");
            void'(sb.pop_back());
            i_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!hold) i_valid = 1'b0;
        // Scramble inputs after acceptance; the result must not follow them
        i_a  = a ^ 64'hDEAD_BEEF_1234_5678;
        i_b  = ~b;
        i_op = ~op;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin @(posedge clk); n++; end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    typedef struct { logic [63:0] a, b; logic [1:0] op; logic [63:0] exp; } vec_t;
    vec_t vecs[$];

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_a = '0; i_b = '0; i_op = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready",  {63'b0, o_ready}, 64'd1);
        chk("reset_valid",  {63'b0, o_valid}, 64'd0);
        chk("reset_result", o_result, 64'd0);
        i_rst = 1'b0;
        @(posedge clk); #1;

        // Hand-computed directed vectors
        vecs.push_back('{64'd3, 64'd5, 2'b00, 64'd15});
        vecs.push_back('{ONES, ONES, 2'b01, 64'd0});
        vecs.push_back('{ONES, ONES, 2'b00, 64'd1});
        vecs.push_back('{ONES, ONES, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2'b11, ONES});
        vecs.push_back('{MIN64, MIN64, 2'b01, 64'h4000_0000_0000_0000});
        vecs.push_back('{MIN64, MIN64, 2'b00, 64'd0});
        vecs.push_back('{MIN64, 64'd2, 2'b11, ONES});
        vecs.push_back('{ONES, MIN64, 2'b01, 64'd0});
        vecs.push_back('{ONES, MIN64, 2'b11, ONES});
        vecs.push_back('{64'd0, 64'd12345, 2'b00, 64'd0});
        vecs.push_back('{64'hFFFF_FFFF, 64'hFFFF_FFFF, 2'b00, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{64'h1_0000_0000, 64'h1_0000_0000, 2'b00, 64'd0});
        vecs.push_back('{64'h1_0000_0000, 64'h1_0000_0000, 2'b10, 64'd1});
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b0);
            wait_drain(200);
        end

        // Downstream stall: result held 10 cycles, new requests refused
        i_ready = 1'b0;
        send(MIN64, 64'd4, 2'b10, 64'd2, 1'b0);
        begin
            int n = 0;
            while (!o_valid && n < 200) begin @(posedge clk); #1; n++; end
        end
        for (int k = 0; k < 10; k++) begin
            i_valid = 1'b1; i_a = 64'd5; i_b = 64'd5; i_op = 2'b00;
            chk("stall_valid",  {63'b0, o_valid}, 64'd1);
            chk("stall_result", o_result, 64'd2);
            chk("stall_ready",  {63'b0, o_ready}, 64'd0);
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        wait_drain(20);
        repeat (80) @(posedge clk);
        #1;
        chk("idle_after_stall", {63'b0, o_ready}, 64'd1);

        // Reset in cycle 30 of BUSY, with i_valid high during reset
        i_a = 64'd123; i_b = 64'd456; i_op = 2'b00; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        i_rst = 1'b1; i_valid = 1'b1; i_a = 64'd9; i_b = 64'd9;
        @(posedge clk); #1;
        chk("abort_valid",  {63'b0, o_valid}, 64'd0);
        chk("abort_ready",  {63'b0, o_ready}, 64'd1);
        chk("abort_result", o_result, 64'd0);
        @(posedge clk); #1;
        i_rst = 1'b0; i_valid = 1'b0;
        chk("no_accept_in_reset", {63'b0, o_ready}, 64'd1);
        send(64'd7, 64'd6, 2'b00, 64'd42, 1'b0);
        wait_drain(200);

        // Back-to-back with i_valid held high, against the reference model
        b2b = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            logic [63:0] a, b;
            logic [1:0]  op;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            op = 2'($urandom_range(0, 3));
            if (k % 50 == 1) a = MIN64;
            if (k % 50 == 2) b = ONES;
            send(a, b, op, ref_mul(a, b, op), 1'b1);
        end
        i_valid = 1'b0;
        wait_drain(200);
        b2b = 1'b0;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
